// File: rtl/magic_cube_scan_ctrl.sv
// magic_cube_scan_ctrl: feeds classified sticker colours to the one-side block and assembles the 162-bit cube map.
// Define SCAN_TIMEOUT_EN to add the WAIT_DONE watchdog (TIMEOUT_CYCLES); otherwise error is tied low.
module magic_cube_scan_ctrl #(
  parameter int FACE_COUNT     = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         color_valid,
  input  logic [2:0]   color_in,
  output logic         color_ready,
  output logic         side_clear,
  output logic         side_enable,
  output logic [8:0]   side_position,
  output logic [2:0]   side_color,
  input  logic [26:0]  side_dout,
  input  logic         side_done,
  output logic [2:0]   face_idx,
  output logic [3:0]   sticker_idx,
  output logic         busy,
  output logic [161:0] cube_state,
  output logic         cube_done,
  output logic         color_err,
  output logic         error
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLEAR      = 3'd1;
  localparam logic [2:0] S_WAIT_COLOR = 3'd2;
  localparam logic [2:0] S_ISSUE      = 3'd3;
  localparam logic [2:0] S_WAIT_DONE  = 3'd4;
  localparam logic [2:0] S_STORE      = 3'd5;
  localparam logic [2:0] S_FINISH     = 3'd6;
  localparam logic [2:0] LAST_FACE    = 3'(FACE_COUNT - 1);
  typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] cnt_t;
  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic         w_accept;
  logic         w_timeout;
  logic         r_color_ready;
  logic         r_side_clear;
  logic         r_side_enable;
  logic [8:0]   r_side_position;
  logic [2:0]   r_side_color;
  logic [2:0]   r_face;
  logic [3:0]   r_sticker;
  logic         r_busy;
  logic [161:0] r_cube;
  logic         r_cube_done;
  logic         r_color_err;
  assign color_ready   = r_color_ready;
  assign side_clear    = r_side_clear;
  assign side_enable   = r_side_enable;
  assign side_position = r_side_position;
  assign side_color    = r_side_color;
  assign face_idx      = r_face;
  assign sticker_idx   = r_sticker;
  assign busy          = r_busy;
  assign cube_state    = r_cube;
  assign cube_done     = r_cube_done;
  assign color_err     = r_color_err;
  always_comb begin
    w_accept = (r_state == S_WAIT_COLOR) && color_valid;
    w_next   = r_state;
    case (r_state)
      S_IDLE:       w_next = start ? S_CLEAR : S_IDLE;
      S_CLEAR:      w_next = S_WAIT_COLOR;
      S_WAIT_COLOR: w_next = color_valid ? S_ISSUE : S_WAIT_COLOR;
      S_ISSUE:      w_next = S_WAIT_DONE;
      S_WAIT_DONE:  w_next = side_done ? ((r_sticker == 4'd8) ? S_STORE : S_WAIT_COLOR)
                                       : (w_timeout ? S_IDLE : S_WAIT_DONE);
      S_STORE:      w_next = (r_face == LAST_FACE) ? S_FINISH : S_CLEAR;
      S_FINISH:     w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_color_ready   <= 1'b0;
      r_side_clear    <= 1'b0;
      r_side_enable   <= 1'b0;
      r_side_position <= '0;
      r_side_color    <= 3'b111;
      r_face          <= '0;
      r_sticker       <= '0;
      r_busy          <= 1'b0;
      r_cube          <= '0;
      r_cube_done     <= 1'b0;
      r_color_err     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_busy        <= w_next != S_IDLE;
      r_color_ready <= w_next == S_WAIT_COLOR;
      r_side_clear  <= (w_next == S_CLEAR) || w_timeout;
      r_side_enable <= w_next == S_ISSUE;
      r_cube_done   <= w_next == S_FINISH;
      if (r_state == S_IDLE && start) begin
        r_face      <= '0;
        r_sticker   <= '0;
        r_color_err <= 1'b0;
      end
      if (w_accept) begin
        r_side_color    <= color_in;
        r_side_position <= 9'd1 << r_sticker;
        if (color_in == 3'b111) r_color_err <= 1'b1;
      end
      if (r_state == S_WAIT_DONE && side_done && r_sticker != 4'd8) r_sticker <= r_sticker + 4'd1;
      if (r_state == S_STORE) begin
        r_cube[r_face*27 +: 27] <= side_dout;
        if (r_face != LAST_FACE) begin
          r_face    <= r_face + 3'd1;
          r_sticker <= '0;
        end
      end
    end
  end
`ifdef SCAN_TIMEOUT_EN
  cnt_t r_cnt;
  logic r_error;
  assign w_timeout = (r_state == S_WAIT_DONE) && !side_done && (r_cnt == cnt_t'(TIMEOUT_CYCLES - 1));
  assign error     = r_error;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_error <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT_DONE) ? r_cnt + cnt_t'(1) : '0;
      if (r_state == S_IDLE && start) r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif
endmodule

// File: doc/magic_cube_scan_ctrl.md
# magic_cube_scan_ctrl

Sequencer that builds the full cube colour map from the per-sticker colour classifier. It takes one classified sticker colour at a time, drives the one-side data-set block with a one-hot position and colour, and waits for that block's `done`. After nine stickers it stores the 27-bit side word; after six faces it presents the 162-bit cube state to the solver front-end.

## Interface
Parameters:
- `FACE_COUNT`, 6: faces per scan; legal range 1..6.
- `TIMEOUT_CYCLES`, 64: `WAIT_DONE` watchdog limit. Used only when `SCAN_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin scan; sampled only in `IDLE`.
- `color_valid` in 1: classifier has a sticker colour.
- `color_in` in 3: sticker colour code; 3'b111 is reserved as invalid.
- `color_ready` out 1: controller accepts `color_in` this cycle.
- `side_clear` out 1: 1-cycle pulse, ORed into the side block's `rst`.
- `side_enable` out 1: 1-cycle pulse, the side block's `enable`.
- `side_position` out 9: one-hot sticker select (bit i = sticker i).
- `side_color` out 3: colour for the selected sticker.
- `side_dout` in 27: assembled side word from the side block.
- `side_done` in 1: side block completion.
- `face_idx` out 3: current face, 0..FACE_COUNT-1.
- `sticker_idx` out 4: current sticker, 0..8.
- `busy` out 1: high in every state except `IDLE`.
- `cube_state` out 162: face f occupies bits [f*27+26 : f*27].
- `cube_done` out 1: 1-cycle pulse on scan completion.
- `color_err` out 1: sticky; at least one 3'b111 colour was accepted during the scan.
- `error` out 1: sticky watchdog flag.

## Operation
States and transitions:
- `IDLE`
  - `start` → `CLEAR`.
  - On that transition: `face_idx` = 0, `sticker_idx` = 0; clear `color_err` and `error`.
- `CLEAR`
  - `side_clear` = 1 for one cycle → `WAIT_COLOR`.
- `WAIT_COLOR`
  - `color_ready` = 1.
  - On `color_valid & color_ready`: latch `color_in` into `side_color` → `ISSUE`.
  - If the latched value is 3'b111, set `color_err`.
- `ISSUE`
  - `side_enable` = 1 for one cycle, with `side_position` = 1 << `sticker_idx` → `WAIT_DONE`.
- `WAIT_DONE`, on `side_done`:
  - if `sticker_idx` == 8 → `STORE`;
  - else `sticker_idx`+1 → `WAIT_COLOR`.
- `STORE`
  - Write `cube_state[face_idx*27 +: 27]` <= `side_dout`.
  - If `face_idx` == FACE_COUNT-1 → `FINISH`.
  - Else `face_idx`+1, `sticker_idx` = 0 → `CLEAR`.
- `FINISH`
  - `cube_done` = 1 for one cycle → `IDLE`.

Boundary rules:
- `start` while `busy` is ignored.
- `color_valid` outside `WAIT_COLOR` is not consumed.
- `side_done` outside `WAIT_DONE` is ignored.
- `side_done` is level-tolerant: `ISSUE` always separates two `WAIT_DONE` visits, so the side block has returned to idle first.
- `cube_state` holds its value after `FINISH` until the next `STORE` overwrites a face. Faces not scanned in an aborted run keep their previous content.
- `side_position` and `side_color` hold their last values between issues.
- Reset mid-scan: return to `IDLE` the next cycle. No `cube_done`.

## Timing
- Reset values:
  - state `IDLE`; `face_idx`, `sticker_idx`, `side_position`, `cube_state` = 0;
  - `side_color` = 3'b111;
  - every other output = 0.
- All outputs are registered.
- Per sticker: 1 cycle in `WAIT_COLOR` (colour already valid) + 1 in `ISSUE` + side-block latency in `WAIT_DONE`.
- Per face: above ×9, + 1 `CLEAR` + 1 `STORE`.
- `cube_done` asserts one cycle after the final `STORE`. `busy` drops the cycle after `cube_done`.
- `color_ready` is high only in `WAIT_COLOR`, so at most one transfer per sticker.

## Configuration
- `SCAN_TIMEOUT_EN` defined:
  - A cycle counter runs in `WAIT_DONE` and clears on entry.
  - When it reaches TIMEOUT_CYCLES without `side_done`: set `error`, pulse `side_clear`, go to `IDLE`. No `cube_done`.
  - `error` clears on the next accepted `start`.
- `SCAN_TIMEOUT_EN` undefined:
  - No counter; `WAIT_DONE` waits indefinitely.
  - `error` tied 0; `TIMEOUT_CYCLES` unused.

## Test plan
- Full scan, FACE_COUNT=6, colours = (face+sticker)%6 always valid → 54 `side_enable` pulses, one-hot positions cycling 0..8; one `cube_done`; `cube_state` matches the side-block model's 6×27-bit words.
- `color_valid` toggled randomly, side-block done delay 3–10 cycles → identical `cube_state` to the no-stall run; `color_ready` never high outside `WAIT_COLOR`.
- `start` pulsed again mid-scan and `side_done` pulsed spuriously in `WAIT_COLOR` → both ignored; sticker count stays 54.
- One sticker colour 3'b111 → `color_err`=1 at `cube_done` and still 1 after; cleared on the next `start`.
- `rst` asserted in face 3 `WAIT_DONE` → next cycle `busy`=0, `cube_state`=0, all pulses 0; a fresh scan then completes normally.
- `SCAN_TIMEOUT_EN`, TIMEOUT_CYCLES=16, `side_done` withheld on sticker 4 → `error`=1 after 16 cycles, `side_clear` pulse, `IDLE`, no `cube_done`.
